// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
//   word_t      : 32-bit instruction/data word
//   pc_t        : 9-bit word address (default ADDR_WIDTH)
//   mem_owner_t : which requester owns the read data returning next cycle
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned PC_WIDTH   = 9;
  localparam int unsigned STRB_WIDTH = WORD_WIDTH / 8;
  // Wide enough for MAX_DATA_BURST up to 15
  localparam int unsigned CNT_WIDTH  = 4;
  localparam int          MEM_LATENCY = 1;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [PC_WIDTH-1:0]   pc_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOAD
  } mem_owner_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch request/response, load-store request/response and
// memory-side signals around the arbiter.
//   slave  : the arbiter (accepts requests, drives the memory)
//   master : pipeline front/back ends plus the RAM
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PC_WIDTH
);

  // Instruction fetch
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_flush;
  logic                  if_rsp_valid;
  word_t                 if_rsp_data;

  // Load / store
  logic                  dm_req_valid;
  logic                  dm_req_ready;
  logic [ADDR_WIDTH-1:0] dm_req_addr;
  logic                  dm_req_we;
  strb_t                 dm_req_strb;
  word_t                 dm_req_wdata;
  logic                  dm_rsp_valid;
  word_t                 dm_rsp_data;

  // Memory
  logic                  mem_en;
  strb_t                 mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  word_t                 mem_wdata;
  word_t                 mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_strb, dm_req_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_addr, dm_req_we, dm_req_strb, dm_req_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous word RAM between instruction fetch and
// load/store. One grant per cycle, data-over-fetch priority with a starvation
// guard, read data returned the cycle after the grant.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : mem_port_arbiter_if.slave (requests, responses, memory drive)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = PC_WIDTH,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_DATA_BURST);

  mem_owner_t           owner_q, owner_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic fetch_starved_c;
  logic dm_grant_c;
  logic if_grant_c;

  // Owner and starvation counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, counter/owner next state and memory drive
  always_comb begin
    fetch_starved_c = 1'b0;
    dm_grant_c      = 1'b0;
    if_grant_c      = 1'b0;
    cnt_d           = cnt_q;
    owner_d         = OWN_NONE;
    bus.mem_en      = 1'b0;
    bus.mem_we      = '0;
    bus.mem_addr    = bus.dm_req_addr;
    bus.mem_wdata   = bus.dm_req_wdata;

    // A waiting fetch that has seen MAX_DATA_BURST data grants takes priority
    fetch_starved_c = bus.if_req_valid && !bus.if_flush && (cnt_q == MAX_CNT);
    dm_grant_c      = reset_n && bus.dm_req_valid && !fetch_starved_c;
    if_grant_c      = reset_n && bus.if_req_valid && !bus.if_flush && !dm_grant_c;

    if (!bus.if_req_valid || if_grant_c) begin
      cnt_d = '0;
    end else if (dm_grant_c && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (if_grant_c) begin
      owner_d = OWN_FETCH;
    end else if (dm_grant_c && !bus.dm_req_we) begin
      owner_d = OWN_LOAD;
    end

    if (dm_grant_c) begin
      bus.mem_en = 1'b1;
      if (bus.dm_req_we) begin
        bus.mem_we = bus.dm_req_strb;
      end
    end else if (if_grant_c) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_req_addr;
    end
  end

  assign bus.dm_req_ready = dm_grant_c;
  assign bus.if_req_ready = if_grant_c;

  // A redirect in the response cycle drops the fetch data; the read is still spent
  assign bus.if_rsp_valid = (owner_q == OWN_FETCH) && !bus.if_flush;
  assign bus.dm_rsp_valid = (owner_q == OWN_LOAD);
  assign bus.if_rsp_data  = bus.mem_rdata;
  assign bus.dm_rsp_data  = bus.mem_rdata;

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port synchronous word memory between the instruction-fetch stage and the load/store stage.
- Grants at most one request per cycle, with data-over-fetch priority and a starvation guard.
- Returns read data one cycle after the grant, and can drop an in-flight fetch on a branch redirect.
- Sits between the pipeline front/back ends and the unified program/data RAM.

## Interface
Parameters:
- ADDR_WIDTH, 9: word address width; matches `pc_t`.
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch waits; legal range 1–15.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH  fetch word address
- if_flush  in  1  redirect; kills the current fetch grant and the pending fetch response
- if_rsp_valid  out  1  fetch data valid
- if_rsp_data  out  32  fetched instruction (`word_t`)
- dm_req_valid  in  1  data request
- dm_req_ready  out  1  data request accepted this cycle
- dm_req_addr  in  ADDR_WIDTH  data word address
- dm_req_we  in  1  1 = store, 0 = load
- dm_req_strb  in  4  byte enables for stores; ignored for loads
- dm_req_wdata  in  32  store data
- dm_rsp_valid  out  1  load data valid; never asserted for stores
- dm_rsp_data  out  32  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  4  byte write enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  read data, valid the cycle after mem_en

## Operation
- A grant is valid && ready in the same cycle. Readies are combinational, and at most one ready is high per cycle.
- Arbitration order:
  - If if_flush is high, if_req_ready = 0.
  - Otherwise, if the starvation counter equals MAX_DATA_BURST and if_req_valid is high, fetch wins.
  - Otherwise data wins, then fetch.
- Starvation counter:
  - Increments on each data grant while if_req_valid is high and fetch is not granted; saturates at MAX_DATA_BURST.
  - Clears on any fetch grant, or in any cycle with if_req_valid low.
- Memory drive on a grant:
  - mem_en = 1 and mem_addr = the granted address.
  - mem_we = dm_req_strb for a store, 0000 otherwise.
  - mem_wdata = dm_req_wdata.
  - With no grant: mem_en = 0, mem_we = 0000, and mem_addr/mem_wdata are don't-care.
- Response owner register `owner` (enum NONE/FETCH/LOAD), updated every cycle:
  - FETCH on a fetch grant, LOAD on a load grant, NONE otherwise (including store grants).
- Response outputs:
  - if_rsp_valid = (owner == FETCH) && !if_flush.
  - dm_rsp_valid = (owner == LOAD).
  - The matching rsp_data = mem_rdata pass-through; the other data output is don't-care.
- Responses have no backpressure; requesters must accept them.
- Requests are not queued. A requester holds valid/addr/data stable until ready.

## Timing
- Reset values, asynchronous: owner = NONE, counter = 0, if_rsp_valid = 0, dm_rsp_valid = 0.
- While reset_n is low: both readies = 0, mem_en = 0, mem_we = 0000.
- Latency: grant in cycle N; response in cycle N+1. Throughput is one access per cycle.
- Back-to-back grants to different requesters are legal; owner simply changes each cycle.
- if_flush in the grant cycle blocks the fetch grant. if_flush in the response cycle suppresses if_rsp_valid; the memory read is still consumed.
- Reset asserted between grant and response: the response is discarded, and no rsp_valid is emitted after reset releases.
- Counter saturated but if_req_valid low: data is granted normally and the counter clears.

## Structure
- Add to the `riscv` package:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} mem_owner_t`
  - `localparam int MEM_LATENCY = 1`
- Reuse `word_t` for all 32-bit data ports and `pc_t` for addresses when ADDR_WIDTH = 9.
- Single module; no sub-module is natural. The counter and owner register are a few lines each.

## Test plan
- Reset release with both valids high:
  - First cycle: dm granted (dm_req_ready = 1, if_req_ready = 0).
  - Next cycle with dm_req_valid low: fetch granted.
- Fetch addr 0x010, mem_rdata = 0x00500093 in cycle N+1 → if_rsp_valid = 1 and if_rsp_data = 0x00500093 in N+1 only; dm_rsp_valid = 0.
- Both valids held high continuously, MAX_DATA_BURST = 4 → grant pattern D,D,D,D,F,D,D,D,D,F…
- Store addr 0x020, strb 0101, wdata 0xAABBCCDD → mem_we = 0101 in grant cycle; no dm_rsp_valid in N+1.
  - Follow with a load of 0x020: dm_rsp_valid in that load's N+1.
- Fetch granted in N, if_flush high in N+1 → if_rsp_valid stays 0.
  - A fetch request with if_flush high gets if_req_ready = 0.
- reset_n pulsed low in N+1 after a load grant → dm_rsp_valid = 0 during and after reset; counter = 0.
